// File: rtl/mem_arbiter_if.sv
// Bus bundle between the datapath cache ports, the RAM and mem_arbiter.
// slave is the arbiter's view; master is the view of whatever drives requests and the RAM status.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        busy;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, busy, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction and data requests onto one single-ported RAM, with
// re-issue on RAM error, a per-attempt timeout, and registered hit/load outputs.
module mem_arbiter #(
  parameter int          TIMEOUT   = 64,
  parameter int          MAX_RETRY = 2,
  parameter logic [31:0] ERR_WORD  = 32'hBAD1BAD1
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  function automatic logic [RW-1:0] retry_inc(input logic [RW-1:0] v);
    return (v >= RETRY_MAX) ? v : v + RW'(1);
  endfunction

  function automatic logic [TW-1:0] tmo_inc(input logic [TW-1:0] v);
    return (v >= TMO_LAST) ? v : v + TW'(1);
  endfunction

  logic [1:0]    state;
  logic          last_grant;   // 1 = data port was served last
  logic          grant_d;
  logic          op_wr;
  logic          gap;
  logic          ihit_r;
  logic          dhit_r;
  logic          err_r;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   iload_r;
  logic [31:0]   dload_r;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_store;

  logic d_req;
  logic pick_d;
  logic in_acc;
  logic attempt;
  logic acc_ok;
  logic acc_retry;
  logic acc_abort;

  always_comb begin
    d_req     = bus.dREN | bus.dWEN;
    pick_d    = d_req & (~bus.iREN | ~last_grant);
    in_acc    = (state == IACC) || (state == DACC);
    attempt   = in_acc & ~gap;
    acc_ok    = attempt && (bus.ramstate == RAM_ACCESS);
    acc_retry = attempt && (bus.ramstate == RAM_ERROR) && (retry_cnt < RETRY_MAX);
    acc_abort = attempt &&
                (((bus.ramstate == RAM_ERROR) && (retry_cnt >= RETRY_MAX)) ||
                 (((bus.ramstate == RAM_FREE) || (bus.ramstate == RAM_BUSY)) &&
                  (tmo_cnt == TMO_LAST)));
  end

  // RAM drive is combinational from state and the latched request; enables drop during a re-issue gap.
  assign bus.ramREN   = attempt & ~op_wr;
  assign bus.ramWEN   = attempt & op_wr;
  assign bus.ramaddr  = in_acc ? lat_addr : 32'h0;
  assign bus.ramstore = (in_acc & op_wr) ? lat_store : 32'h0;
  assign bus.busy     = (state != IDLE);
  assign bus.ihit     = ihit_r;
  assign bus.dhit     = dhit_r;
  assign bus.err      = err_r;
  assign bus.iload    = iload_r;
  assign bus.dload    = dload_r;

  always_ff @(posedge CLK) begin
    if (state == IDLE) begin
      lat_addr  <= pick_d ? bus.daddr : bus.iaddr;
      lat_store <= bus.dstore;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      grant_d    <= 1'b0;
      op_wr      <= 1'b0;
      gap        <= 1'b0;
      ihit_r     <= 1'b0;
      dhit_r     <= 1'b0;
      err_r      <= 1'b0;
      retry_cnt  <= '0;
      tmo_cnt    <= '0;
      iload_r    <= 32'h0;
      dload_r    <= 32'h0;
    end else begin
      ihit_r <= 1'b0;
      dhit_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          retry_cnt <= '0;
          tmo_cnt   <= '0;
          gap       <= 1'b0;
          if (d_req || bus.iREN) begin
            grant_d <= pick_d;
            op_wr   <= pick_d & bus.dWEN;
            state   <= pick_d ? DACC : IACC;
          end
        end
        IACC, DACC: begin
          if (acc_ok || acc_abort) begin
            state <= RESP;
            err_r <= acc_abort;
            if (state == IACC) begin
              ihit_r  <= 1'b1;
              iload_r <= acc_ok ? bus.ramload : ERR_WORD;
            end else begin
              dhit_r <= 1'b1;
              if (!op_wr) dload_r <= acc_ok ? bus.ramload : ERR_WORD;
            end
          end else if (acc_retry) begin
            retry_cnt <= retry_inc(retry_cnt);
            tmo_cnt   <= '0;
            gap       <= 1'b1;
          end else if (gap) begin
            gap <= 1'b0;
          end else begin
            tmo_cnt <= tmo_inc(tmo_cnt);
          end
        end
        RESP: begin
          last_grant <= grant_d;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected hits, a negedge
// monitor pops and compares them; the stimulus process also plays the RAM.
module tb_mem_arbiter;
  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [31:0] ERRW     = 32'hBAD1BAD1;

  typedef struct {
    logic        port;   // 1 = data
    logic        err;
    logic [31:0] load;
    int          cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST;
  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(8), .MAX_RETRY(2), .ERR_WORD(ERRW)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_ihit = 0;
  int          n_dhit = 0;
  exp_t        expq[$];
  logic [1:0]  script[$];
  logic        use_fixed;
  logic [31:0] fixed_word;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Advance one cycle, then answer any enabled RAM access from the script (ACCESS when empty).
  task automatic tick();
    @(posedge CLK);
    #1;
    if (bus.ramREN || bus.ramWEN) begin
      if (script.size() > 0) bus.ramstate = script.pop_front();
      else bus.ramstate = RS_ACCESS;
      bus.ramload = use_fixed ? fixed_word : word_at(bus.ramaddr);
    end else begin
      bus.ramstate = RS_FREE;
      bus.ramload  = 32'h0;
    end
  endtask

  task automatic push(input logic port, input logic e, input logic [31:0] ld, input int c);
    exp_t x;
    x.port = port; x.err = e; x.load = ld; x.cyc = c;
    expq.push_back(x);
  endtask

  task automatic wait_hit(input bit is_d, input string name);
    int snap;
    int b;
    snap = is_d ? n_dhit : n_ihit;
    b = 0;
    while (((is_d ? n_dhit : n_ihit) == snap) && b < 40) begin
      tick();
      b++;
    end
    if (b >= 40) begin
      checks++;
      failures++;
      $display("FAIL %s: no hit within 40 cycles, required one", name);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.ihit || bus.dhit) begin
        if (bus.ihit) n_ihit++;
        if (bus.dhit) n_dhit++;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_hit: got ihit=%b dhit=%b required none (cycle %0d)",
                   bus.ihit, bus.dhit, cyc);
        end else begin
          e = expq.pop_front();
          check("hit_ihit", {31'b0, bus.ihit}, {31'b0, ~e.port});
          check("hit_dhit", {31'b0, bus.dhit}, {31'b0, e.port});
          check("hit_err", {31'b0, bus.err}, {31'b0, e.err});
          check("hit_load", e.port ? bus.dload : bus.iload, e.load);
          check("hit_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000");
    $fatal(1);
  end

  initial begin
    int k;
    int b;
    int sd;
    int si;
    nRST = 1'b1;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = RS_FREE;
    use_fixed = 0; fixed_word = 0;
    #2 nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ihit", {31'b0, bus.ihit}, 0);
    check("rst_dhit", {31'b0, bus.dhit}, 0);
    check("rst_err", {31'b0, bus.err}, 0);
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_iload", bus.iload, 0);
    check("rst_dload", bus.dload, 0);
    check("rst_ramen", {30'b0, bus.ramREN, bus.ramWEN}, 0);
    check("rst_ramaddr", bus.ramaddr, 0);
    check("rst_ramstore", bus.ramstore, 0);
    nRST = 1'b1;
    tick();

    // Zero-wait instruction read
    k = cyc;
    use_fixed = 1; fixed_word = 32'h8C010004;
    bus.iREN = 1; bus.iaddr = 32'h40;
    push(0, 0, 32'h8C010004, k + 2);
    tick();
    check("t1_ramREN", {31'b0, bus.ramREN}, 1);
    check("t1_ramaddr", bus.ramaddr, 32'h40);
    wait_hit(0, "t1_wait");
    bus.iREN = 0;
    check("t1_idle", {31'b0, bus.busy}, 0);
    use_fixed = 0;

    // Simultaneous requests, each dropped after its own hit
    tick();
    k = cyc;
    bus.iaddr = 32'h44; bus.daddr = 32'h200; bus.iREN = 1; bus.dREN = 1;
    push(1, 0, word_at(32'h200), k + 2);
    push(0, 0, word_at(32'h44), k + 5);
    sd = n_dhit; si = n_ihit; b = 0;
    while ((bus.iREN || bus.dREN) && b < 40) begin
      tick();
      b++;
      if (n_dhit != sd) bus.dREN = 0;
      if (n_ihit != si) bus.iREN = 0;
    end
    if (b >= 40) begin
      checks++; failures++;
      $display("FAIL t2_wait: requests still pending after 40 cycles, required served");
      bus.iREN = 0; bus.dREN = 0;
    end

    // Both held continuously: D, I, D, I
    tick();
    k = cyc;
    bus.iREN = 1; bus.dREN = 1;
    push(1, 0, word_at(32'h200), k + 2);
    push(0, 0, word_at(32'h44), k + 5);
    push(1, 0, word_at(32'h200), k + 8);
    push(0, 0, word_at(32'h44), k + 11);
    si = n_ihit; b = 0;
    while ((n_ihit - si) < 2 && b < 60) begin
      tick();
      b++;
    end
    bus.iREN = 0; bus.dREN = 0;
    if (b >= 60) begin
      checks++; failures++;
      $display("FAIL t2b_wait: got %0d ihits required 2", n_ihit - si);
    end

    // Write with three BUSY cycles; dload keeps the last read value
    tick();
    k = cyc;
    script = {RS_BUSY, RS_BUSY, RS_BUSY, RS_ACCESS};
    bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
    push(1, 0, word_at(32'h200), k + 5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_ramWEN", {31'b0, bus.ramWEN}, 1);
      check("t3_ramstore", bus.ramstore, 32'hDEADBEEF);
    end
    check("t3_ramREN", {31'b0, bus.ramREN}, 0);
    wait_hit(1, "t3_wait");
    bus.dWEN = 0;

    // One ERROR then ACCESS
    tick();
    k = cyc;
    script = {RS_ERROR, RS_ACCESS};
    use_fixed = 1; fixed_word = 32'h1234;
    bus.dREN = 1; bus.daddr = 32'h300;
    push(1, 0, 32'h1234, k + 4);
    tick();
    check("t4a_first", {31'b0, bus.ramREN}, 1);
    tick();
    check("t4a_gap", {31'b0, bus.ramREN}, 0);
    check("t4a_busy", {31'b0, bus.busy}, 1);
    wait_hit(1, "t4a_wait");
    bus.dREN = 0;

    // Persistent ERROR: three attempts separated by gaps, then abort
    tick();
    k = cyc;
    script = {RS_ERROR, RS_ERROR, RS_ERROR};
    bus.dREN = 1; bus.daddr = 32'h304;
    push(1, 1, ERRW, k + 6);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t4b_enable", {31'b0, bus.ramREN}, i % 2);
    end
    wait_hit(1, "t4b_wait");
    bus.dREN = 0;
    use_fixed = 0;

    // Timeout with RAM stuck BUSY
    tick();
    k = cyc;
    repeat (12) script.push_back(RS_BUSY);
    bus.iREN = 1; bus.iaddr = 32'h80;
    push(0, 1, ERRW, k + 9);
    repeat (8) tick();
    check("t5_last_attempt", {31'b0, bus.ramREN}, 1);
    wait_hit(0, "t5_wait");
    bus.iREN = 0;
    script.delete();

    // Reset during a data access
    tick();
    k = cyc;
    repeat (10) script.push_back(RS_BUSY);
    bus.dREN = 1; bus.daddr = 32'h400;
    tick();
    tick();
    check("t6_pre_ramREN", {31'b0, bus.ramREN}, 1);
    #2 nRST = 1'b0;
    #1;
    check("t6_ramREN", {31'b0, bus.ramREN}, 0);
    check("t6_ramaddr", bus.ramaddr, 0);
    check("t6_busy", {31'b0, bus.busy}, 0);
    check("t6_iload", bus.iload, 0);
    check("t6_dload", bus.dload, 0);
    check("t6_hits", {29'b0, bus.ihit, bus.dhit, bus.err}, 0);
    script.delete();
    repeat (2) tick();
    k = cyc;
    nRST = 1'b1;
    push(1, 0, word_at(32'h400), k + 2);
    wait_hit(1, "t6_wait");
    bus.dREN = 0;

    repeat (4) tick();
    check("queue_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
